// File: rtl/serial_add_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_ctrl_pkg
//  Description : Shared definitions for the bit-serial adder sequencer.
//                Holds the FSM state encoding and a helper that sizes the
//                bit counter.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_add_ctrl_pkg;

    // Sequencer state encoding; 2'd3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Bit counter width: enough to count 0..WIDTH-1, never less than 1 bit.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage : serial_add_ctrl_pkg
`default_nettype wire

// File: rtl/serial_add_ctrl_fa_bit.sv
`default_nettype none
// ============================================================================
//  Module      : fa_bit (with helper ha_bit)
//  Description : Purely combinational 1-bit full adder built from two half
//                adders and an OR gate.
//  Ports       : i_a, i_b, i_c  - addend bits and carry-in
//                o_s            - sum bit
//                o_c            - carry-out
//  Revision    : 1.0 - initial release
// ============================================================================
module ha_bit (
    input  logic i_x,
    input  logic i_y,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_x ^ i_y;
    assign o_c = i_x & i_y;
endmodule : ha_bit

module fa_bit (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    logic w_s0;
    logic w_c0;
    logic w_c1;

    ha_bit u_ha0 (
        .i_x (i_a),
        .i_y (i_b),
        .o_s (w_s0),
        .o_c (w_c0)
    );

    ha_bit u_ha1 (
        .i_x (w_s0),
        .i_y (i_c),
        .o_s (o_s),
        .o_c (w_c1)
    );

    // The two half-adder carries are never both set, so OR suffices.
    assign o_c = w_c0 | w_c1;
endmodule : fa_bit
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_ctrl
//  Description : Bit-serial addition sequencer. Captures two WIDTH-bit
//                operands on start, feeds them LSB-first through a single
//                full-adder cell with a registered carry, then presents
//                sum/cout with a one-cycle done pulse.
//  Ports       : clk    - clock, rising edge
//                rst    - synchronous active-high reset
//                start  - request, sampled only in IDLE
//                a, b   - operands, sampled on the accepting edge
//                cin    - carry-in, sampled on the accepting edge
//                busy   - high whenever not IDLE
//                done   - one-cycle pulse in DONE
//                sum    - registered result
//                cout   - registered carry-out of bit WIDTH-1
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int              CNT_W      = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_res_sh;
    logic               r_c;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_s;
    logic               w_c;
    logic               w_last;
    logic [WIDTH-1:0]   w_res_nxt;

    fa_bit u_fa (
        .i_a (r_a_sh[0]),
        .i_b (r_b_sh[0]),
        .i_c (r_c),
        .o_s (w_s),
        .o_c (w_c)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign w_res_nxt = w_s;
        end else begin : g_res_wn
            logic w_unused_res_lsb;
            assign w_res_nxt        = {w_s, r_res_sh[WIDTH-1:1]};
            assign w_unused_res_lsb = r_res_sh[0];
        end
    endgenerate

    assign w_last = (r_cnt == c_CNT_LAST);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = S_IDLE;
        case (r_state)
            S_IDLE:  w_state_nxt = start  ? S_RUN  : S_IDLE;
            S_RUN:   w_state_nxt = w_last ? S_DONE : S_RUN;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: shift registers, carry, counter, result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_c      <= 1'b0;
            r_cnt    <= '0;
            sum      <= '0;
            cout     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sh   <= a;
                        r_b_sh   <= b;
                        r_c      <= cin;
                        r_res_sh <= '0;
                        r_cnt    <= '0;
                    end
                end
                S_RUN: begin
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_res_sh <= w_res_nxt;
                    r_c      <= w_c;
                    if (w_last) begin
                        sum  <= w_res_nxt;
                        cout <= w_c;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);

endmodule : serial_add_ctrl
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_add_ctrl
//  Description : Self-checking bench for serial_add_ctrl at WIDTH=1, 8, 13.
//                Expected results come from plain integer addition.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] a_in;
    logic [12:0] b_in;
    logic        cin_in;
    logic        start_w1, start_w8, start_w13;

    logic        busy_w1, done_w1, cout_w1;
    logic [0:0]  sum_w1;
    logic        busy_w8, done_w8, cout_w8;
    logic [7:0]  sum_w8;
    logic        busy_w13, done_w13, cout_w13;
    logic [12:0] sum_w13;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [63:0] prev_sum [3];
    logic [63:0] prev_cout[3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_add_ctrl #(.WIDTH(1)) u_dut_w1 (
        .clk(clk), .rst(rst), .start(start_w1), .a(a_in[0:0]), .b(b_in[0:0]),
        .cin(cin_in), .busy(busy_w1), .done(done_w1), .sum(sum_w1), .cout(cout_w1)
    );
    serial_add_ctrl #(.WIDTH(8)) u_dut_w8 (
        .clk(clk), .rst(rst), .start(start_w8), .a(a_in[7:0]), .b(b_in[7:0]),
        .cin(cin_in), .busy(busy_w8), .done(done_w8), .sum(sum_w8), .cout(cout_w8)
    );
    serial_add_ctrl #(.WIDTH(13)) u_dut_w13 (
        .clk(clk), .rst(rst), .start(start_w13), .a(a_in), .b(b_in),
        .cin(cin_in), .busy(busy_w13), .done(done_w13), .sum(sum_w13), .cout(cout_w13)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int wid(input int sel);
        return (sel == 0) ? 1 : (sel == 1) ? 8 : 13;
    endfunction

    task automatic set_start(input int sel, input logic v);
        case (sel)
            0:       start_w1  = v;
            1:       start_w8  = v;
            default: start_w13 = v;
        endcase
    endtask

    task automatic peek(input int sel, output logic bz, output logic dn,
                        output logic [63:0] s, output logic [63:0] co);
        case (sel)
            0:       begin bz = busy_w1;  dn = done_w1;  s = 64'(sum_w1);  co = 64'(cout_w1);  end
            1:       begin bz = busy_w8;  dn = done_w8;  s = 64'(sum_w8);  co = 64'(cout_w8);  end
            default: begin bz = busy_w13; dn = done_w13; s = 64'(sum_w13); co = 64'(cout_w13); end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation from an IDLE cycle; returns in IDLE, #1 after an edge.
    // disturb: keep start high during RUN with different operands.
    task automatic run_op(input int sel, input logic [63:0] av, input logic [63:0] bv,
                          input logic cv, input bit disturb);
        int          w;
        int          lat;
        logic [63:0] mask, full, es, ec, s, co;
        logic        bz, dn;
        w    = wid(sel);
        mask = (64'd1 << w) - 64'd1;
        full = (av & mask) + (bv & mask) + 64'(cv);
        es   = full & mask;
        ec   = full >> w;
        a_in   = av[12:0];
        b_in   = bv[12:0];
        cin_in = cv;
        set_start(sel, 1'b1);
        tick();
        if (disturb) begin
            a_in = 13'h11; b_in = 13'h22; cin_in = 1'b0;
        end else begin
            set_start(sel, 1'b0);
            a_in = 13'($urandom); b_in = 13'($urandom); cin_in = 1'($urandom);
        end
        lat = 0;
        peek(sel, bz, dn, s, co);
        while (!dn && lat < w + 4) begin
            chk("busy_run", 64'(bz), 64'd1);
            chk("sum_hold", s, prev_sum[sel]);
            chk("cout_hold", co, prev_cout[sel]);
            tick();
            lat++;
            peek(sel, bz, dn, s, co);
        end
        set_start(sel, 1'b0);
        chk("latency", 64'(lat), 64'(w));
        chk("done_hi", 64'(dn), 64'd1);
        chk("busy_done", 64'(bz), 64'd1);
        chk("sum", s, es);
        chk("cout", co, ec);
        prev_sum[sel]  = es;
        prev_cout[sel] = ec;
        tick();
        peek(sel, bz, dn, s, co);
        chk("done_width", 64'(dn), 64'd0);
        chk("busy_idle", 64'(bz), 64'd0);
    endtask

    initial begin
        logic        bz, dn;
        logic [63:0] s, co;
        int          t_done[3];
        int          seen_done;
        logic [7:0]  bb_a[3];
        logic [7:0]  bb_b[3];

        rst = 1'b1; start_w1 = 0; start_w8 = 0; start_w13 = 0;
        a_in = '0; b_in = '0; cin_in = 0;
        for (int i = 0; i < 3; i++) begin prev_sum[i] = '0; prev_cout[i] = '0; end
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            peek(i, bz, dn, s, co);
            chk("rst_busy", 64'(bz), 64'd0);
            chk("rst_done", 64'(dn), 64'd0);
            chk("rst_sum", s, 64'd0);
            chk("rst_cout", co, 64'd0);
        end

        // Directed cases at WIDTH=8
        run_op(1, 64'h00, 64'h00, 1'b0, 0);
        run_op(1, 64'hFF, 64'h01, 1'b0, 0);
        run_op(1, 64'hA5, 64'h5A, 1'b1, 1);
        run_op(1, 64'h12, 64'h34, 1'b0, 0);

        // Reset in the 4th RUN cycle aborts the operation
        a_in = 13'h77; b_in = 13'h66; cin_in = 1'b1;
        set_start(1, 1'b1);
        tick();
        set_start(1, 1'b0);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        peek(1, bz, dn, s, co);
        chk("abort_busy", 64'(bz), 64'd0);
        chk("abort_done", 64'(dn), 64'd0);
        chk("abort_sum", s, 64'd0);
        chk("abort_cout", co, 64'd0);
        prev_sum[1] = '0; prev_cout[1] = '0;
        prev_sum[0] = '0; prev_cout[0] = '0;
        prev_sum[2] = '0; prev_cout[2] = '0;
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            peek(1, bz, dn, s, co);
            if (dn) seen_done++;
        end
        chk("abort_no_done", 64'(seen_done), 64'd0);
        run_op(1, 64'h3C, 64'h0F, 1'b0, 0);

        // Back-to-back with start held high
        bb_a[0] = 8'h7F; bb_b[0] = 8'h01;
        bb_a[1] = 8'h80; bb_b[1] = 8'h80;
        bb_a[2] = 8'h12; bb_b[2] = 8'h34;
        cin_in = 1'b0;
        set_start(1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            logic [8:0] full;
            int         n;
            a_in = 13'(bb_a[k]);
            b_in = 13'(bb_b[k]);
            full = 9'(bb_a[k]) + 9'(bb_b[k]);
            n = 0;
            peek(1, bz, dn, s, co);
            while (!bz && n < 4) begin tick(); n++; peek(1, bz, dn, s, co); end
            n = 0;
            while (!dn && n < 14) begin tick(); n++; peek(1, bz, dn, s, co); end
            if (k == 2) set_start(1, 1'b0);
            t_done[k] = cyc;
            chk("b2b_done", 64'(dn), 64'd1);
            chk("b2b_sum", s, 64'(full[7:0]));
            chk("b2b_cout", co, 64'(full[8]));
            if (k > 0) chk("b2b_period", 64'(t_done[k] - t_done[k-1]), 64'd10);
            tick();
            peek(1, bz, dn, s, co);
            chk("b2b_done_width", 64'(dn), 64'd0);
        end
        prev_sum[1] = 64'h46; prev_cout[1] = 64'd0;
        tick();

        // WIDTH=1
        run_op(0, 64'h1, 64'h1, 1'b1, 0);
        for (int i = 0; i < 8; i++)
            run_op(0, 64'($urandom), 64'($urandom), 1'($urandom), 0);

        // Random sweeps
        for (int i = 0; i < 1000; i++)
            run_op(1, 64'($urandom), 64'($urandom), 1'($urandom), (i % 7) == 3);
        for (int i = 0; i < 1000; i++)
            run_op(2, 64'($urandom), 64'($urandom), 1'($urandom), (i % 5) == 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_serial_add_ctrl
`default_nettype wire
